// File: rtl/truth_table_sweeper.sv
// Sweeps a 4-input vector 0..15 into a logic block under test, captures two output truth tables and reports disagreements.
// Optional build macro SWEEP_HALT_EN: stop the sweep at the first mismatch and keep the failing vector on w..z.
module truth_table_sweeper #(
  parameter int HOLD_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        w,
  output logic        x,
  output logic        y,
  output logic        z,
  input  logic        f_a,
  input  logic        f_b,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_a,
  output logic [15:0] table_b,
  output logic [4:0]  mismatch_count,
  output logic        first_fail_valid,
  output logic [3:0]  first_fail_idx
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t      state;
  state_t      state_next;
  logic [3:0]  idx;
  logic [7:0]  hold_cnt;
  logic [3:0]  vec;
  logic        start_accept;
  logic        sample;
  logic        mismatch;
  logic        halt;
  logic        end_sweep;

  // A start in RUN is dropped, including one coinciding with the final sampling edge.
  assign start_accept = start && (state != RUN);
  assign sample       = (state == RUN) && (hold_cnt == HOLD_LAST);
  assign mismatch     = f_a ^ f_b;

`ifdef SWEEP_HALT_EN
  assign halt = mismatch;
`else
  assign halt = 1'b0;
`endif

  assign end_sweep = sample && ((idx == 4'hF) || halt);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_accept) state_next = RUN;
      RUN:     if (end_sweep)    state_next = DONE;
      DONE:    if (start_accept) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    vec  = 4'd0;
    case (state)
      RUN: begin
        busy = 1'b1;
        vec  = idx;
      end
      DONE: begin
        done = 1'b1;
`ifdef SWEEP_HALT_EN
        if (first_fail_valid) vec = idx;
`endif
      end
      default: ;
    endcase
  end

  assign {w, x, y, z} = vec;

  // Result registers are plain flops (no RAM), so they all take the synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx              <= 4'd0;
      hold_cnt         <= 8'd0;
      table_a          <= 16'd0;
      table_b          <= 16'd0;
      mismatch_count   <= 5'd0;
      first_fail_valid <= 1'b0;
      first_fail_idx   <= 4'd0;
    end else if (start_accept) begin
      idx              <= 4'd0;
      hold_cnt         <= 8'd0;
      table_a          <= 16'd0;
      table_b          <= 16'd0;
      mismatch_count   <= 5'd0;
      first_fail_valid <= 1'b0;
      first_fail_idx   <= 4'd0;
    end else if (state == RUN) begin
      if (sample) begin
        table_a[idx] <= f_a;
        table_b[idx] <= f_b;
        if (mismatch) begin
          mismatch_count <= mismatch_count + 5'd1;
          if (!first_fail_valid) begin
            first_fail_valid <= 1'b1;
            first_fail_idx   <= idx;
          end
        end
        // idx freezes on the final vector (or failing vector when halting).
        if (!end_sweep) begin
          idx      <= idx + 4'd1;
          hold_cnt <= 8'd0;
        end
      end else begin
        hold_cnt <= hold_cnt + 8'd1;
      end
    end
  end

endmodule
